conv_kxk_window_gen: RTL and testbench

- Parametrised successor to the fixed 3x3 pixel buffer feeding conv_3x3_core.
- Accepts one raster-order pixel stream per frame and emits one 3x3 window per output position.
- New capabilities: configurable dilation (RATE), "same" zero padding at all four borders, a runtime stride-2 mode, and an end-of-frame flush so every centre pixel gets a window.
- Output windows feed conv_3x3_core or a multi-channel accumulator directly.

---
 rtl/conv_kxk_window_gen.sv | 162 ++++++++++++++++
 tb/tb_conv_kxk_window_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_kxk_window_gen.sv
// Dilated 3x3 window generator with "same" zero padding, optional stride-2 decimation and end-of-frame flush.
// Windows are registered: valid_out one cycle after the pixel that completes them; ready_in drops only while flushing.
module conv_kxk_window_gen #(
  parameter int DATA_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 64,
  parameter int IMAGE_HEIGHT = 64,
  parameter int RATE         = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  input  logic [DATA_WIDTH-1:0]   pxl_in,
  input  logic                    stride2,
  output logic                    ready_in,
  output logic [9*DATA_WIDTH-1:0] win_out,
  output logic                    valid_out,
  output logic                    frame_done
);

  localparam int N     = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int PRE   = RATE * IMAGE_WIDTH + RATE;
  localparam int DEPTH = 2 * PRE + 1;

  typedef logic [CNT_WIDTH-1:0] cnt_t;
  typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;

  localparam cnt_t PRE_C      = cnt_t'(PRE);
  localparam cnt_t FLUSH_LAST = cnt_t'(PRE - 1);
  localparam cnt_t LAST_IDX   = cnt_t'(N - 1);
  localparam cnt_t R_C        = cnt_t'(RATE);
  localparam cnt_t ROW_HI     = cnt_t'(IMAGE_HEIGHT - 1 - RATE);
  localparam cnt_t COL_HI     = cnt_t'(IMAGE_WIDTH - 1 - RATE);
  localparam cnt_t LAST_R     = cnt_t'(IMAGE_HEIGHT - 1);
  localparam cnt_t LAST_C     = cnt_t'(IMAGE_WIDTH - 1);
  localparam cnt_t LAST_R2    = cnt_t'(2 * ((IMAGE_HEIGHT - 1) / 2));
  localparam cnt_t LAST_C2    = cnt_t'(2 * ((IMAGE_WIDTH - 1) / 2));

  state_t                 state;
  cnt_t                   in_cnt;
  cnt_t                   cr;
  cnt_t                   cc;
  logic                   stride_q;
  logic                   acc;
  logic                   shift;
  logic                   emit;
  logic                   win_keep;
  logic                   win_last;
  logic [DATA_WIDTH-1:0]  shift_dat;
  logic [9*DATA_WIDTH-1:0] win_nxt;
  logic [DATA_WIDTH-1:0]  sr [DEPTH];

  assign ready_in  = (state != FLUSH);
  assign acc       = valid_in && ready_in;
  assign shift     = acc || (state == FLUSH);
  assign shift_dat = (state == FLUSH) ? '0 : pxl_in;
  assign emit      = (acc && (in_cnt >= PRE_C)) || (state == FLUSH);
  assign win_keep  = !stride_q || (!cr[0] && !cc[0]);
  assign win_last  = stride_q ? ((cr == LAST_R2) && (cc == LAST_C2))
                              : ((cr == LAST_R) && (cc == LAST_C));

  // sr[0] holds the newest pixel; the centre always sits at sr[PRE]
  always_ff @(posedge clk) begin
    if (shift) begin
      sr[0] <= shift_dat;
      for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
    end
  end

  // Taps are taken from the post-shift view so the window registers on the accepting edge
  for (genvar t = 0; t < 9; t++) begin : g_tap
    localparam int DR  = t / 3 - 1;
    localparam int DC  = t % 3 - 1;
    localparam int IDX = PRE - DR * RATE * IMAGE_WIDTH - DC * RATE;
    logic [DATA_WIDTH-1:0] tap_raw;
    logic                  row_ok;
    logic                  col_ok;

    if (IDX == 0) begin : g_new
      assign tap_raw = shift_dat;
    end else begin : g_old
      assign tap_raw = sr[IDX-1];
    end

    if (DR < 0) begin : g_up
      assign row_ok = (cr >= R_C);
    end else if (DR > 0) begin : g_dn
      assign row_ok = (cr <= ROW_HI);
    end else begin : g_rmid
      assign row_ok = 1'b1;
    end

    if (DC < 0) begin : g_lf
      assign col_ok = (cc >= R_C);
    end else if (DC > 0) begin : g_rt
      assign col_ok = (cc <= COL_HI);
    end else begin : g_cmid
      assign col_ok = 1'b1;
    end

    assign win_nxt[t*DATA_WIDTH +: DATA_WIDTH] = (row_ok && col_ok) ? tap_raw : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FILL;
      in_cnt     <= '0;
      cr         <= '0;
      cc         <= '0;
      stride_q   <= 1'b0;
      win_out    <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= emit && win_keep;
      frame_done <= emit && win_keep && win_last;
      if (emit && win_keep) win_out <= win_nxt;

      if (acc && (state == FILL) && (in_cnt == '0)) stride_q <= stride2;

      if (emit) begin
        if (cc == LAST_C) begin
          cc <= '0;
          cr <= cr + cnt_t'(1);
        end else begin
          cc <= cc + cnt_t'(1);
        end
      end

      case (state)
        FILL: begin
          if (acc) begin
            in_cnt <= in_cnt + cnt_t'(1);
            if (in_cnt == PRE_C) state <= STREAM;
          end
        end
        STREAM: begin
          if (acc) begin
            if (in_cnt == LAST_IDX) begin
              state  <= FLUSH;
              in_cnt <= '0;
            end else begin
              in_cnt <= in_cnt + cnt_t'(1);
            end
          end
        end
        FLUSH: begin
          if (in_cnt == FLUSH_LAST) begin
            state  <= FILL;
            in_cnt <= '0;
            cr     <= '0;
            cc     <= '0;
          end else begin
            in_cnt <= in_cnt + cnt_t'(1);
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_kxk_window_gen.sv
// Scoreboard bench: a 4x4/R=1 instance and an 8x8/R=2 instance, expected windows queued at stimulus time.
module tb_conv_kxk_window_gen;

  typedef struct packed {
    logic [143:0] w;
    logic         done;
  } exp_t;

  logic         clk = 1'b0;
  logic         a_rst, a_valid, a_stride2, a_ready, a_vo, a_fd;
  logic [15:0]  a_pxl;
  logic [143:0] a_win;
  logic         b_rst, b_valid, b_stride2, b_ready, b_vo, b_fd;
  logic [15:0]  b_pxl;
  logic [143:0] b_win;

  exp_t         qa[$];
  exp_t         qb[$];
  logic [143:0] a_cap[$];
  logic [143:0] b_cap[$];
  exp_t         ea, eb;
  int           a_cnt, a_fd_cnt, b_cnt, b_fd_cnt;
  int           n_vec = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  conv_kxk_window_gen #(.DATA_WIDTH(16), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .RATE(1), .CNT_WIDTH(16)) u_a (
    .clk(clk), .reset(a_rst), .valid_in(a_valid), .pxl_in(a_pxl), .stride2(a_stride2),
    .ready_in(a_ready), .win_out(a_win), .valid_out(a_vo), .frame_done(a_fd));

  conv_kxk_window_gen #(.DATA_WIDTH(16), .IMAGE_WIDTH(8), .IMAGE_HEIGHT(8), .RATE(2), .CNT_WIDTH(16)) u_b (
    .clk(clk), .reset(b_rst), .valid_in(b_valid), .pxl_in(b_pxl), .stride2(b_stride2),
    .ready_in(b_ready), .win_out(b_win), .valid_out(b_vo), .frame_done(b_fd));

  task automatic check_win(input string n, input logic [143:0] act, input logic [143:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic check_int(input string n, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  function automatic logic [143:0] w9(input int a0, input int a1, input int a2, input int a3,
                                      input int a4, input int a5, input int a6, input int a7, input int a8);
    return {16'(a8), 16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  // Reference window straight from image coordinates; pixel value = raster index + 1 + off
  function automatic logic [143:0] model_win(input int wd, input int ht, input int r8, input int r, input int c, input int off);
    logic [143:0] w;
    int rr, cc;
    w = '0;
    for (int t = 0; t < 9; t++) begin
      rr = r + (t / 3 - 1) * r8;
      cc = c + (t % 3 - 1) * r8;
      if (rr >= 0 && rr < ht && cc >= 0 && cc < wd) w[t*16 +: 16] = 16'(rr * wd + cc + 1 + off);
    end
    return w;
  endfunction

  task automatic push_a(input int off, input bit s2, input int n_centres);
    exp_t e;
    for (int i = 0; i < n_centres; i++) begin
      if (!s2 || ((i / 4) % 2 == 0 && (i % 4) % 2 == 0)) begin
        e.w = model_win(4, 4, 1, i / 4, i % 4, off);
        e.done = 1'b0;
        qa.push_back(e);
      end
    end
    if (n_centres == 16) begin
      e = qa[qa.size()-1];
      e.done = 1'b1;
      qa[qa.size()-1] = e;
    end
  endtask

  task automatic push_b();
    exp_t e;
    for (int i = 0; i < 64; i++) begin
      e.w = model_win(8, 8, 2, i / 8, i % 8, 0);
      e.done = (i == 63);
      qb.push_back(e);
    end
  endtask

  task automatic send_a(input int off, input bit s2, input bit gaps, input bit flush_vld, input int npix);
    int idx, guard, low;
    idx = 0; guard = 0; low = 0;
    while (idx < npix && guard < 2000) begin
      @(negedge clk);
      guard++;
      a_pxl     = 16'(idx + 1 + off);
      a_stride2 = (idx == 0) ? s2 : !s2;
      a_valid   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (a_valid && a_ready) idx++;
    end
    check_int("a_pixels_accepted", idx, npix);
    @(negedge clk);
    if (npix < 16) begin
      a_valid = 1'b0;
    end else begin
      guard = 0;
      while (!a_ready && guard < 100) begin
        a_valid = flush_vld;
        a_pxl   = 16'hdead;
        low++;
        guard++;
        @(negedge clk);
      end
      a_valid = 1'b0;
      check_int("a_ready_low_cycles", low, 5);
    end
  endtask

  task automatic send_b();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      b_valid = 1'b1;
      b_pxl   = 16'(i + 1);
    end
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((qa.size() != 0 || qb.size() != 0) && g < 200) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    check_int("scoreboard_empty", qa.size() + qb.size(), 0);
  endtask

  task automatic cap_a(input string n, input int idx, input logic [143:0] exp);
    if (idx < a_cap.size()) check_win(n, a_cap[idx], exp);
    else check_int(n, a_cap.size(), idx + 1);
  endtask

  task automatic cap_b(input string n, input int idx, input logic [143:0] exp);
    if (idx < b_cap.size()) check_win(n, b_cap[idx], exp);
    else check_int(n, b_cap.size(), idx + 1);
  endtask

  task automatic clear_a();
    a_cnt = 0; a_fd_cnt = 0;
    a_cap.delete();
  endtask

  always @(negedge clk) begin
    if (a_vo) begin
      a_cnt++;
      if (a_fd) a_fd_cnt++;
      a_cap.push_back(a_win);
      if (qa.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL a_unexpected_window: got %h expected none", a_win);
      end else begin
        ea = qa.pop_front();
        check_win("a_win", a_win, ea.w);
        check_int("a_frame_done", int'(a_fd), int'(ea.done));
      end
    end else if (a_fd) begin
      n_vec++; n_fail++;
      $display("FAIL a_frame_done_without_valid: got 1 expected 0");
    end
  end

  always @(negedge clk) begin
    if (b_vo) begin
      b_cnt++;
      if (b_fd) b_fd_cnt++;
      b_cap.push_back(b_win);
      if (qb.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL b_unexpected_window: got %h expected none", b_win);
      end else begin
        eb = qb.pop_front();
        check_win("b_win", b_win, eb.w);
        check_int("b_frame_done", int'(b_fd), int'(eb.done));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    a_rst = 1'b0; b_rst = 1'b0;
    a_valid = 1'b0; a_pxl = '0; a_stride2 = 1'b0;
    b_valid = 1'b0; b_pxl = '0; b_stride2 = 1'b0;
    b_cnt = 0; b_fd_cnt = 0;
    clear_a();
    #1 a_rst = 1'b1; b_rst = 1'b1;
    #2;
    check_win("a_reset_win", a_win, '0);
    check_int("a_reset_valid", int'(a_vo), 0);
    check_int("a_reset_done", int'(a_fd), 0);
    check_int("a_reset_ready", int'(a_ready), 1);
    check_win("b_reset_win", b_win, '0);
    check_int("b_reset_ready", int'(b_ready), 1);
    @(negedge clk);
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;

    // 4x4 continuous, stride 1
    push_a(0, 1'b0, 16);
    send_a(0, 1'b0, 1'b0, 1'b0, 16);
    drain();
    check_int("a_s1_window_count", a_cnt, 16);
    check_int("a_s1_frame_done_count", a_fd_cnt, 1);
    cap_a("a_centre_0_0", 0, w9(0, 0, 0, 0, 1, 2, 0, 5, 6));
    cap_a("a_centre_1_1", 5, w9(1, 2, 3, 5, 6, 7, 9, 10, 11));
    cap_a("a_centre_3_3", 15, w9(11, 12, 0, 15, 16, 0, 0, 0, 0));

    // 4x4 stride 2, stride2 input toggled after the first pixel
    clear_a();
    push_a(0, 1'b1, 16);
    send_a(0, 1'b1, 1'b0, 1'b0, 16);
    drain();
    check_int("a_s2_window_count", a_cnt, 4);
    check_int("a_s2_frame_done_count", a_fd_cnt, 1);
    cap_a("a_s2_centre_0_2", 1, w9(0, 0, 0, 2, 3, 4, 6, 7, 8));
    cap_a("a_s2_centre_2_2", 3, w9(6, 7, 8, 10, 11, 12, 14, 15, 16));

    // 8x8 with dilation 2
    push_b();
    send_b();
    drain();
    check_int("b_window_count", b_cnt, 64);
    check_int("b_frame_done_count", b_fd_cnt, 1);
    cap_b("b_centre_0_0", 0, w9(0, 0, 0, 0, 1, 3, 0, 17, 19));
    cap_b("b_centre_2_2", 18, w9(1, 3, 5, 17, 19, 21, 33, 35, 37));

    // random input gaps, junk offered while flushing
    clear_a();
    push_a(0, 1'b0, 16);
    send_a(0, 1'b0, 1'b1, 1'b1, 16);
    drain();
    check_int("a_gaps_window_count", a_cnt, 16);
    check_int("a_gaps_frame_done_count", a_fd_cnt, 1);

    // asynchronous reset after 9 pixels, then a clean frame
    clear_a();
    push_a(0, 1'b0, 4);
    send_a(0, 1'b0, 1'b0, 1'b0, 9);
    #2 a_rst = 1'b1;
    #1;
    check_win("a_midreset_win", a_win, '0);
    check_int("a_midreset_valid", int'(a_vo), 0);
    check_int("a_midreset_done", int'(a_fd), 0);
    check_int("a_midreset_ready", int'(a_ready), 1);
    check_int("a_prereset_window_count", a_cnt, 4);
    @(negedge clk);
    a_rst = 1'b0;
    clear_a();
    push_a(0, 1'b0, 16);
    send_a(0, 1'b0, 1'b0, 1'b0, 16);
    drain();
    check_int("a_postreset_window_count", a_cnt, 16);
    cap_a("a_postreset_centre_1_1", 5, w9(1, 2, 3, 5, 6, 7, 9, 10, 11));

    // back-to-back frames with distinct pixel values, stride 1 then stride 2
    clear_a();
    push_a(0, 1'b0, 16);
    send_a(0, 1'b0, 1'b0, 1'b1, 16);
    push_a(100, 1'b1, 16);
    send_a(100, 1'b1, 1'b0, 1'b1, 16);
    drain();
    check_int("a_b2b_window_count", a_cnt, 20);
    check_int("a_b2b_frame_done_count", a_fd_cnt, 2);
    cap_a("a_b2b_f2_centre_0_0", 16, w9(0, 0, 0, 0, 101, 102, 0, 105, 106));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
